// File: rtl/fu_scalar_ls_queue_if.sv
// Bundle of dispatch-side, LS-unit-side and writeback signals around the scalar load/store queue.
// The queue uses the slave modport; whatever drives dispatch and models the LS unit uses master.
interface fu_scalar_ls_queue_if #(
    parameter int DEPTH  = 4,
    parameter int WORD_W = 32,
    parameter int TAG_W  = 5
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              issue_valid;
    logic              issue_ready;
    logic [1:0]        issue_mem_type;
    logic [WORD_W-1:0] issue_rs1;
    logic [WORD_W-1:0] issue_rs2;
    logic [WORD_W-1:0] issue_imm;
    logic [TAG_W-1:0]  issue_rd;
    logic              flush;
    logic              ls_enable;
    logic [1:0]        ls_mem_type;
    logic [WORD_W-1:0] ls_rs1;
    logic [WORD_W-1:0] ls_rs2;
    logic [WORD_W-1:0] ls_imm;
    logic              ls_dhit;
    logic [WORD_W-1:0] ls_dmemload;
    logic              wb_valid;
    logic [TAG_W-1:0]  wb_rd;
    logic [WORD_W-1:0] wb_data;
    logic              store_done;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  issue_valid, issue_mem_type, issue_rs1, issue_rs2, issue_imm, issue_rd,
        input  flush, ls_dhit, ls_dmemload,
        output issue_ready, ls_enable, ls_mem_type, ls_rs1, ls_rs2, ls_imm,
        output wb_valid, wb_rd, wb_data, store_done, count
    );

    modport master (
        output issue_valid, issue_mem_type, issue_rs1, issue_rs2, issue_imm, issue_rd,
        output flush, ls_dhit, ls_dmemload,
        input  issue_ready, ls_enable, ls_mem_type, ls_rs1, ls_rs2, ls_imm,
        input  wb_valid, wb_rd, wb_data, store_done, count
    );
endinterface

// File: rtl/fu_scalar_ls_queue.sv
// In-order request queue feeding the scalar load/store unit: holds the head op until dhit,
// then retires it with a registered load writeback or store completion pulse.
module fu_scalar_ls_queue #(
    parameter int DEPTH  = 4,
    parameter int WORD_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic                   CLK,
    input  logic                   RST,
    fu_scalar_ls_queue_if.slave    bus
);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [1:0]       MT_NONE  = 2'd0;
    localparam logic [1:0]       MT_LOAD  = 2'd1;
    localparam logic [1:0]       MT_STORE = 2'd2;

    typedef struct packed {
        logic [1:0]        mem_type;
        logic [WORD_W-1:0] rs1;
        logic [WORD_W-1:0] rs2;
        logic [WORD_W-1:0] imm;
        logic [TAG_W-1:0]  rd;
    } entry_t;

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    count_w;
    logic              has_head;
    logic              ready;
    logic              push;
    logic              pop;
    entry_t            new_entry;
    entry_t            head;
    entry_t            slots [DEPTH];

    logic              wb_valid_q, wb_valid_d;
    logic [TAG_W-1:0]  wb_rd_q, wb_rd_d;
    logic [WORD_W-1:0] wb_data_q, wb_data_d;
    logic              store_done_q, store_done_d;

    assign count_w  = wr_ptr_q - rd_ptr_q;
    assign has_head = (count_w != '0);
    assign ready    = (count_w != FULL_CNT);
    assign push     = bus.issue_valid && ready && !bus.flush &&
                      (bus.issue_mem_type == MT_LOAD || bus.issue_mem_type == MT_STORE);
    assign pop      = bus.ls_dhit && has_head;
    assign head     = slots[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        new_entry.mem_type = bus.issue_mem_type;
        new_entry.rs1      = bus.issue_rs1;
        new_entry.rs2      = bus.issue_rs2;
        new_entry.imm      = bus.issue_imm;
        new_entry.rd       = bus.issue_rd;
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            entry_t slot_q;
            always_ff @(posedge CLK) begin
                if (push && wr_ptr_q[PTR_W-1:0] == PTR_W'(gi)) begin
                    slot_q <= new_entry;
                end
            end
            assign slots[gi] = slot_q;
        end
    endgenerate

    always_comb begin
        rd_ptr_d     = rd_ptr_q + {{PTR_W{1'b0}}, pop};
        wr_ptr_d     = wr_ptr_q + {{PTR_W{1'b0}}, push};
        wb_valid_d   = pop && head.mem_type == MT_LOAD && head.rd != '0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        store_done_d = pop && head.mem_type == MT_STORE;
        // Flush keeps only the in-flight head, unless that head retires this same cycle.
        if (bus.flush) begin
            wr_ptr_d = rd_ptr_d + {{PTR_W{1'b0}}, (has_head && !pop)};
        end
        if (wb_valid_d) begin
            wb_rd_d   = head.rd;
            wb_data_d = bus.ls_dmemload;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            store_done_q <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            store_done_q <= store_done_d;
        end
    end

    assign bus.issue_ready = ready;
    assign bus.ls_enable   = has_head;
    assign bus.ls_mem_type = has_head ? head.mem_type : MT_NONE;
    assign bus.ls_rs1      = has_head ? head.rs1 : '0;
    assign bus.ls_rs2      = has_head ? head.rs2 : '0;
    assign bus.ls_imm      = has_head ? head.imm : '0;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_rd       = wb_rd_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.store_done  = store_done_q;
    assign bus.count       = count_w;
endmodule

// File: tb/tb_fu_scalar_ls_queue.sv
// Directed scenarios plus random traffic for the scalar load/store queue, checked every cycle
// against a queue-based reference model.
module tb_fu_scalar_ls_queue;
    localparam int DEPTH  = 4;
    localparam int WORD_W = 32;
    localparam int TAG_W  = 5;

    typedef struct {
        logic [1:0]  mem_type;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
    } ent_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    fu_scalar_ls_queue_if #(.DEPTH(DEPTH), .WORD_W(WORD_W), .TAG_W(TAG_W)) bus();

    fu_scalar_ls_queue #(.DEPTH(DEPTH), .WORD_W(WORD_W), .TAG_W(TAG_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of ops plus the expected registered pulses.
    ent_t        mq[$];
    logic        m_ok = 1'b0;
    logic        e_wb_valid, e_store_done;
    logic [4:0]  e_wb_rd;
    logic [31:0] e_wb_data;

    always @(posedge CLK) begin
        if (RST) begin
            mq.delete();
            m_ok = 1'b1;
            e_wb_valid = 1'b0; e_store_done = 1'b0; e_wb_rd = '0; e_wb_data = '0;
        end else if (m_ok) begin
            logic did_pop, acc;
            ent_t h, n;
            did_pop = bus.ls_dhit && mq.size() != 0;
            acc = bus.issue_valid && mq.size() < DEPTH && !bus.flush &&
                  (bus.issue_mem_type == 2'd1 || bus.issue_mem_type == 2'd2);
            e_wb_valid = 1'b0;
            e_store_done = 1'b0;
            if (did_pop) begin
                h = mq.pop_front();
                if (h.mem_type == 2'd1 && h.rd != 0) begin
                    e_wb_valid = 1'b1; e_wb_rd = h.rd; e_wb_data = bus.ls_dmemload;
                end
                if (h.mem_type == 2'd2) e_store_done = 1'b1;
            end
            if (bus.flush) begin
                if (did_pop) mq.delete();
                else while (mq.size() > 1) void'(mq.pop_back());
            end else if (acc) begin
                n.mem_type = bus.issue_mem_type; n.rs1 = bus.issue_rs1; n.rs2 = bus.issue_rs2;
                n.imm = bus.issue_imm; n.rd = bus.issue_rd;
                mq.push_back(n);
            end
        end
    end

    always @(negedge CLK) begin
        if (m_ok && !RST) begin
            logic ne;
            ne = mq.size() != 0;
            chk("count", 64'(bus.count), 64'(mq.size()));
            chk("issue_ready", 64'(bus.issue_ready), 64'(mq.size() != DEPTH));
            chk("ls_enable", 64'(bus.ls_enable), 64'(ne));
            chk("ls_mem_type", 64'(bus.ls_mem_type), ne ? 64'(mq[0].mem_type) : 64'd0);
            chk("ls_rs1", 64'(bus.ls_rs1), ne ? 64'(mq[0].rs1) : 64'd0);
            chk("ls_rs2", 64'(bus.ls_rs2), ne ? 64'(mq[0].rs2) : 64'd0);
            chk("ls_imm", 64'(bus.ls_imm), ne ? 64'(mq[0].imm) : 64'd0);
            chk("wb_valid", 64'(bus.wb_valid), 64'(e_wb_valid));
            chk("wb_rd", 64'(bus.wb_rd), 64'(e_wb_rd));
            chk("wb_data", 64'(bus.wb_data), 64'(e_wb_data));
            chk("store_done", 64'(bus.store_done), 64'(e_store_done));
        end
    end

    // Apply one cycle of inputs, then return at the following falling edge.
    task automatic drv(input logic v, input logic [1:0] t, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] im, input logic [4:0] rd, input logic fl, input logic dh,
                       input logic [31:0] dm);
        bus.issue_valid = v; bus.issue_mem_type = t; bus.issue_rs1 = r1; bus.issue_rs2 = r2;
        bus.issue_imm = im; bus.issue_rd = rd; bus.flush = fl; bus.ls_dhit = dh; bus.ls_dmemload = dm;
        @(negedge CLK);
    endtask

    task automatic idle();
        drv(1'b0, 2'd0, 0, 0, 0, 0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        logic [31:0] st_rs2 [4];
        st_rs2[0] = 32'h11; st_rs2[1] = 32'h22; st_rs2[2] = 32'h33; st_rs2[3] = 32'h44;
        bus.issue_valid = 0; bus.issue_mem_type = 0; bus.issue_rs1 = 0; bus.issue_rs2 = 0;
        bus.issue_imm = 0; bus.issue_rd = 0; bus.flush = 0; bus.ls_dhit = 0; bus.ls_dmemload = 0;
        RST = 1'b1;
        @(negedge CLK); @(negedge CLK);
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
        chk("rst_enable", 64'(bus.ls_enable), 64'd0);
        RST = 1'b0;

        // 1: single load, held until dhit
        drv(1, 2'd1, 32'h100, 0, 32'h8, 5'd3, 0, 0, 0);
        chk("t1_enable", 64'(bus.ls_enable), 64'd1);
        chk("t1_rs1", 64'(bus.ls_rs1), 64'h100);
        chk("t1_imm", 64'(bus.ls_imm), 64'h8);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("t1_hold_rs1", 64'(bus.ls_rs1), 64'h100);
        end
        drv(0, 2'd0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
        chk("t1_wb_valid", 64'(bus.wb_valid), 64'd1);
        chk("t1_wb_rd", 64'(bus.wb_rd), 64'd3);
        chk("t1_wb_data", 64'(bus.wb_data), 64'hDEADBEEF);
        chk("t1_count", 64'(bus.count), 64'd0);

        // 2: fill with stores, reject fifth, drain back-to-back
        for (int i = 0; i < 4; i++) drv(1, 2'd2, 32'h200 + i, st_rs2[i], 0, 0, 0, 0, 0);
        chk("t2_full_count", 64'(bus.count), 64'd4);
        chk("t2_ready", 64'(bus.issue_ready), 64'd0);
        drv(1, 2'd2, 32'h999, 32'h55, 0, 0, 0, 0, 0);
        chk("t2_reject", 64'(bus.count), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_rs2", 64'(bus.ls_rs2), 64'(st_rs2[i]));
            drv(0, 2'd0, 0, 0, 0, 0, 0, 1, 0);
            chk("t2_store_done", 64'(bus.store_done), 64'd1);
        end
        chk("t2_empty", 64'(bus.count), 64'd0);

        // 3: simultaneous push and pop at count 2
        drv(1, 2'd1, 32'hA, 0, 0, 5'd5, 0, 0, 0);
        drv(1, 2'd1, 32'hB, 0, 0, 5'd6, 0, 0, 0);
        drv(1, 2'd1, 32'hC, 0, 0, 5'd7, 0, 1, 32'h77);
        chk("t3_count", 64'(bus.count), 64'd2);
        chk("t3_head", 64'(bus.ls_rs1), 64'hB);
        drv(0, 2'd0, 0, 0, 0, 0, 0, 1, 0);
        drv(0, 2'd0, 0, 0, 0, 0, 0, 1, 0);

        // 4: flush with a push in the same cycle keeps only the head
        for (int i = 1; i <= 3; i++) drv(1, 2'd2, 32'(i), 0, 0, 0, 0, 0, 0);
        drv(1, 2'd2, 32'h9, 0, 0, 0, 1, 0, 0);
        chk("t4_count", 64'(bus.count), 64'd1);
        chk("t4_head", 64'(bus.ls_rs1), 64'd1);
        drv(0, 2'd0, 0, 0, 0, 0, 0, 1, 0);
        chk("t4_done", 64'(bus.store_done), 64'd1);
        chk("t4_empty", 64'(bus.count), 64'd0);

        // 5: flush together with dhit at count 3
        for (int i = 1; i <= 3; i++) drv(1, 2'd1, 32'(i), 0, 0, 5'd4, 0, 0, 0);
        drv(0, 2'd0, 0, 0, 0, 0, 1, 1, 32'h1234);
        chk("t5_count", 64'(bus.count), 64'd0);
        chk("t5_wb_valid", 64'(bus.wb_valid), 64'd1);
        chk("t5_wb_data", 64'(bus.wb_data), 64'h1234);

        // 6: rd=0 load, dhit on empty queue, reset mid-operation
        drv(1, 2'd1, 32'h40, 0, 0, 5'd0, 0, 0, 0);
        drv(0, 2'd0, 0, 0, 0, 0, 0, 1, 32'h5555);
        chk("t6_rd0_wb", 64'(bus.wb_valid), 64'd0);
        drv(0, 2'd0, 0, 0, 0, 0, 0, 1, 32'h6666);
        chk("t6_empty_wb", 64'(bus.wb_valid), 64'd0);
        chk("t6_empty_count", 64'(bus.count), 64'd0);
        drv(1, 2'd2, 32'h1, 0, 0, 0, 0, 0, 0);
        drv(1, 2'd2, 32'h2, 0, 0, 0, 0, 0, 0);
        chk("t6_pre_rst", 64'(bus.count), 64'd2);
        RST = 1'b1;
        drv(0, 2'd0, 0, 0, 0, 0, 0, 1, 0);
        RST = 1'b0;
        chk("t6_rst_count", 64'(bus.count), 64'd0);
        chk("t6_rst_enable", 64'(bus.ls_enable), 64'd0);
        chk("t6_rst_done", 64'(bus.store_done), 64'd0);

        // Random traffic, checked each cycle by the model
        for (int i = 0; i < 3000; i++) begin
            RST = ($urandom_range(0, 127) == 0);
            drv($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom_range(0, 15) == 0,
                $urandom_range(0, 1) == 1, $urandom);
        end
        RST = 1'b0;
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
